// File: rtl/mux32_pkg.sv
// Shared sizes and types for the registered 32:1 bit selector.
package mux32_pkg;

    localparam int MUX_WIDTH = 32;
    localparam int MUX_SEL_W = 5;

    typedef logic [MUX_WIDTH-1:0] mux_word_t;
    typedef logic [MUX_SEL_W-1:0] mux_sel_t;

endpackage : mux32_pkg

// File: rtl/mux2_cell.sv
// One-bit 2:1 mux: the leaf element of the selector tree.
// y follows a when s is 0, b when s is 1.
module mux2_cell (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);

    // Plain steering; no state.
    always_comb begin
        y = s ? b : a;
    end

endmodule : mux2_cell

// File: rtl/mux32_reg.sv
// Registered WIDTH:1 single-bit selector: out <= in[sel] one cycle after a
// valid sample, with out_valid as the registered copy of in_valid.
//
// Handshake: valid-only, no ready. A sample is taken on every rising edge
// where in_valid is 1 and rst is 0; the result appears on out with out_valid
// high exactly one cycle later. The block never stalls, so back-to-back
// valid cycles each produce a result. When in_valid is 0, in/sel are
// ignored (may be X), out holds its last value and out_valid drops to 0.
module mux32_reg
    import mux32_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH,
    parameter int SEL_W = MUX_SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic [SEL_W-1:0] sel,
    input  logic             in_valid,
    output logic             out,
    output logic             out_valid
);

    logic sel_bit;
    logic out_d;
    logic out_q;
    logic out_valid_d;
    logic out_valid_q;

    // Binary mux tree: level k halves the candidates using sel[k]; level 0
    // pairs adjacent input bits, so the surviving bit is in[sel].
    for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
        localparam int N = WIDTH >> (k + 1);
        logic [2*N-1:0] lvl_in;
        logic [N-1:0]   lvl_out;

        if (k == 0) begin : g_first
            assign lvl_in = in;
        end else begin : g_next
            assign lvl_in = g_lvl[k-1].lvl_out;
        end

        for (genvar i = 0; i < N; i++) begin : g_cell
            mux2_cell u_cell (
                .a (lvl_in[2*i]),
                .b (lvl_in[2*i+1]),
                .s (sel[k]),
                .y (lvl_out[i])
            );
        end
    end

    assign sel_bit = g_lvl[SEL_W-1].lvl_out[0];

    // Next-state: capture the selected bit only on a valid sample, else hold;
    // the in_valid guard keeps an X on in/sel away from the register.
    always_comb begin
        out_d       = out_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            out_d = sel_bit;
        end
    end

    // Output registers with synchronous reset taking priority over in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule : mux32_reg

// File: tb/tb_mux32_reg.sv
// Directed and random bench for mux32_reg. Inputs are driven 1 time unit
// after each rising edge; outputs are checked 1 time unit after the edge
// that captured them.
module tb_mux32_reg;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          clk;
    logic          rst;
    logic [W-1:0]  in_w;
    logic [SW-1:0] sel;
    logic          in_valid;
    logic          out;
    logic          out_valid;

    int errors;
    int checks;

    logic [1:0] exp_q[$];

    mux32_reg dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in_w),
        .sel       (sel),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [W-1:0] d,
                         input logic [SW-1:0] s, input logic v);
        rst      = r;
        in_w     = d;
        sel      = s;
        in_valid = v;
    endtask

    task automatic test_reset();
        drive(1'b1, 32'hFFFF_FFFF, 5'd0, 1'b1);
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (out !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d out=%b out_valid=%b expected out=0 out_valid=0",
                         c, out, out_valid);
            end
        end
        drive(1'b0, 32'hFFFF_FFFF, 5'd0, 1'b1);
        tick();
        checks++;
        if (out !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_release out=%b out_valid=%b expected out=1 out_valid=1",
                     out, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0]  vin [6];
        logic [SW-1:0] vsel[6];
        logic          vexp[6];
        vin[0] = 32'hEEEE_EEEE; vsel[0] = 5'd15; vexp[0] = 1'b1;
        vin[1] = 32'hEE0E_5EA0; vsel[1] = 5'd2;  vexp[1] = 1'b0;
        vin[2] = 32'hEEEE_5EEE; vsel[2] = 5'd11; vexp[2] = 1'b1;
        vin[3] = 32'h0000_50A0; vsel[3] = 5'd8;  vexp[3] = 1'b0;
        vin[4] = 32'h1002_00E5; vsel[4] = 5'd6;  vexp[4] = 1'b1;
        vin[5] = 32'h0607_A061; vsel[5] = 5'd1;  vexp[5] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, vin[i], vsel[i], 1'b1);
            tick();
            checks++;
            if (out !== vexp[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL directed_%0d in=%h sel=%0d out=%b out_valid=%b expected out=%b out_valid=1",
                         i, vin[i], vsel[i], out, out_valid, vexp[i]);
            end
        end
    endtask

    // Back-to-back valid samples with no idle cycles between them.
    task automatic test_back_to_back();
        logic [SW-1:0] bsel[3];
        logic          bexp[3];
        bsel[0] = 5'd0;  bexp[0] = 1'b1;
        bsel[1] = 5'd31; bexp[1] = 1'b1;
        bsel[2] = 5'd16; bexp[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h8000_0001, bsel[i], 1'b1);
            tick();
            checks++;
            if (out !== bexp[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bounds sel=%0d out=%b out_valid=%b expected out=%b out_valid=1",
                         bsel[i], out, out_valid, bexp[i]);
            end
        end
        for (int k = 0; k < W; k++) begin
            logic [W-1:0] one_hot;
            one_hot = 32'h1 << k;
            drive(1'b0, one_hot, 5'(k), 1'b1);
            tick();
            checks++;
            if (out !== 1'b1 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL walk_hit k=%0d out=%b out_valid=%b expected out=1 out_valid=1",
                         k, out, out_valid);
            end
            drive(1'b0, one_hot, 5'((k + 1) % W), 1'b1);
            tick();
            checks++;
            if (out !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL walk_miss k=%0d out=%b out_valid=%b expected out=0 out_valid=1",
                         k, out, out_valid);
            end
        end
    endtask

    task automatic test_hold();
        drive(1'b0, 32'h0000_FFFF, 5'd3, 1'b1);
        tick();
        checks++;
        if (out !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_load out=%b out_valid=%b expected out=1 out_valid=1", out, out_valid);
        end
        drive(1'b0, 32'h0000_0000, 5'd3, 1'b0);
        tick();
        checks++;
        if (out !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle out=%b out_valid=%b expected out=1 out_valid=0", out, out_valid);
        end
        drive(1'b0, 'x, 'x, 1'b0);
        tick();
        checks++;
        if (out !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_xin out=%b out_valid=%b expected out=1 out_valid=0", out, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 32'h0000_0010, 5'd4, 1'b1);
        tick();
        checks++;
        if (out !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre out=%b out_valid=%b expected out=1 out_valid=1", out, out_valid);
        end
        drive(1'b1, 32'hFFFF_FFFF, 5'd9, 1'b1);
        tick();
        checks++;
        if (out !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst out=%b out_valid=%b expected out=0 out_valid=0", out, out_valid);
        end
        drive(1'b0, 32'hFFFF_FFFF, 5'd9, 1'b0);
        tick();
        checks++;
        if (out !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_idle out=%b out_valid=%b expected out=0 out_valid=0", out, out_valid);
        end
        drive(1'b0, 32'h0200_0000, 5'd25, 1'b1);
        tick();
        checks++;
        if (out !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_resume out=%b out_valid=%b expected out=1 out_valid=1", out, out_valid);
        end
    endtask

    // Random stream against a one-cycle-delayed reference held in exp_q.
    task automatic test_random();
        logic          model_out;
        logic [1:0]    exp;
        logic [W-1:0]  r_in;
        logic [SW-1:0] r_sel;
        logic          r_v;
        int            rand_errs;
        model_out = out;
        rand_errs = 0;
        for (int c = 0; c < 10000; c++) begin
            r_in  = $urandom();
            r_sel = 5'($urandom_range(0, W - 1));
            r_v   = 1'($urandom_range(0, 1));
            if (r_v) model_out = r_in[r_sel];
            exp_q.push_back({model_out, r_v});
            drive(1'b0, r_in, r_sel, r_v);
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (out !== exp[1] || out_valid !== exp[0]) begin
                errors++;
                rand_errs++;
                if (rand_errs <= 10)
                    $display("FAIL random cyc=%0d in=%h sel=%0d v=%b out=%b out_valid=%b expected out=%b out_valid=%b",
                             c, r_in, r_sel, r_v, out, out_valid, exp[1], exp[0]);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        drive(1'b1, '0, '0, 1'b0);
        #1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mux32_reg

// File: doc/mux32_reg.md
Name: mux32_reg

Overview:
- Registered 32:1 single-bit selector: picks bit `in[sel]` from a 32-bit word and drives it on `out`.
- Used wherever one status/flag bit must be chosen from a 32-bit vector by a 5-bit index, e.g. bit-test logic or debug probe selection.
- One clock cycle of latency, with a simple valid qualifier so downstream logic knows when `out` is meaningful.

Parameters:
- WIDTH, 32, number of data inputs; must be a power of 2, minimum 2.
- SEL_W, 5, select width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock; the only clock in the block.
- rst  input  1  synchronous, active-high reset.
- in  input  WIDTH  data word; bit i is candidate i.
- sel  input  SEL_W  unsigned index of the bit to forward.
- in_valid  input  1  qualifies `in`/`sel` this cycle.
- out  output  1  registered selected bit.
- out_valid  output  1  registered copy of `in_valid`.

Behaviour:
- Interface is fixed: one clock, `clk`; reset `rst` is synchronous and active-high.
- All state updates on the rising edge of `clk`. `rst` is sampled only at the edge; no asynchronous path.
- Reset values: `out` = 0, `out_valid` = 0. Reset has priority over `in_valid`.
- Select function: `sel_bit` = `in[sel]`, purely combinational. Index 0 is the LSB of `in`; index WIDTH-1 is the MSB. Every `sel` value is legal; there is no out-of-range case.
- Edge with `rst`=0, `in_valid`=1: `out` <= `in[sel]`, `out_valid` <= 1.
- Edge with `rst`=0, `in_valid`=0: `out` holds its previous value, `out_valid` <= 0.
- Latency is exactly 1 cycle. Throughput is one selection per cycle; back-to-back valid cycles are fully supported with no bubbles.
- No handshake backpressure: the block never stalls and has no ready signal.
- Reset mid-stream: any sample in flight is discarded. The first cycle after `rst` deasserts shows `out` = 0 and `out_valid` = 0 unless `in_valid` was high at that edge.
- X-safety: with `in_valid`=0, `in`/`sel` may be X without corrupting `out`.
- Combinational path: `in`/`sel` to the `out` register through a log2(WIDTH)-level mux tree. No combinational path from any input to any output.

Decomposition:
- Shared package mux32_pkg:
  - localparams MUX_WIDTH = 32 and MUX_SEL_W = 5.
  - typedef `mux_word_t` = logic[MUX_WIDTH-1:0].
  - typedef `mux_sel_t` = logic[MUX_SEL_W-1:0].
- One natural sub-module, mux2_cell: a 1-bit 2:1 mux with inputs a, b, s and output y.
  - The top builds a binary tree of WIDTH-1 mux2_cell instances via generate.
  - Level k is steered by `sel[k]`; level 0 pairs adjacent input bits.
  - The output register and valid logic stay in mux32_reg.

Test Plan:
- Reset: hold `rst`=1 for 2 cycles with `in`=32'hFFFFFFFF, `sel`=0, `in_valid`=1 -> `out`=0 and `out_valid`=0 throughout; one cycle after release, `out`=1 and `out_valid`=1.
- Directed vectors, `in_valid`=1, each checked 1 cycle later:
  - 32'hEEEEEEEE, `sel`=15 -> 1
  - 32'hEE0E5EA0, `sel`=2 -> 0
  - 32'hEEEE5EEE, `sel`=11 -> 1
  - 32'h000050A0, `sel`=8 -> 0
  - 32'h100200E5, `sel`=6 -> 1
  - 32'h0607A061, `sel`=1 -> 0
- Bounds: 32'h80000001 with `sel`=0 -> 1, `sel`=31 -> 1, `sel`=16 -> 0. Walking-one `in` = 1<<k with `sel`=k -> 1, and `sel`=(k+1)%32 -> 0, for all k.
- Hold: apply 32'h0000FFFF, `sel`=3, valid -> `out`=1. Then drop `in_valid` and change to `in`=0 -> `out` stays 1, `out_valid`=0.
- Reset mid-stream: back-to-back valid vectors, assert `rst` for 1 cycle -> `out`=0 and `out_valid`=0 the next cycle; stream resumes correctly afterward.
- Random: 10k cycles of random `in`/`sel`/`in_valid`, compared against a 1-cycle-delayed reference model of `in[sel]`.
